// File: rtl/sram_mem_controller.sv
// sram_mem_controller
// Bridges 32-bit MEM-stage loads/stores to a 16-bit asynchronous SRAM by
// issuing two halfword phases (low half first, then high half). Each phase
// lasts ACCESS_CYCLES clocks. SRAM pins are registered so that they change
// cleanly on clock edges.
//
// Handshake: wr_en/rd_en are level requests that the MEM stage holds steady
// while ready=0. The ready output is 1 either when nothing is requested in
// IDLE, or in the single DONE cycle that ends an access. The pipeline treats
// the clock edge that ends DONE as the point where the access is accepted.
// Any request present in the IDLE cycle after DONE is a new access.
module sram_mem_controller #(
  parameter logic [31:0] BASE_ADDR     = 32'd1024,
  parameter int          ACCESS_CYCLES = 2,
  parameter int          SRAM_ADDR_W   = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [15:0]            sram_dq_out,
  output logic                   sram_dq_oe,
  input  logic [15:0]            sram_dq_in,
  output logic                   sram_we_n,
  output logic                   sram_oe_n,
  output logic [1:0]             o_dbg_state
);

  // Counter width is at least one bit, so ACCESS_CYCLES=2 still has a counter.
  localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic [SRAM_ADDR_W-2:0] r_idx;
  logic [31:0]            r_wdata;
  logic                   r_is_wr;
  logic [31:0]            r_read_data;
  logic [SRAM_ADDR_W-1:0] r_sram_addr;
  logic [15:0]            r_dq_out;
  logic                   r_dq_oe;
  logic                   r_we_n;
  logic                   r_oe_n;

  logic                   w_req;
  logic [SRAM_ADDR_W:0]   w_offset;
  logic [SRAM_ADDR_W-2:0] w_idx;
  logic [CNT_W-1:0]       w_cnt_inc;
  logic                   w_last;
  logic                   w_next_we_n;
  logic                   w_unused_bits;

  // Word index relative to BASE_ADDR. Only the low bits of the 32-bit
  // difference are needed, and modular subtraction on those bits gives the
  // same result, so there is no range check.
  assign w_offset      = address[SRAM_ADDR_W:0] - BASE_ADDR[SRAM_ADDR_W:0];
  assign w_idx         = w_offset[SRAM_ADDR_W:2];
  assign w_unused_bits = ^{address[31:SRAM_ADDR_W+1], w_offset[1:0]};

  assign w_req     = wr_en | rd_en;
  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_last    = (r_cnt == LAST_CNT);
  // WE is released on the last cycle of a phase. This gives address/data
  // hold time after the WE rising edge.
  assign w_next_we_n = !r_is_wr || (w_cnt_inc == LAST_CNT);

  // Combinational ready, so a request stalls the pipeline in its first cycle.
  always_comb begin
    ready = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
  end

  // Sequencer: state, phase counter, latched request and registered SRAM pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_is_wr     <= 1'b0;
      r_read_data <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
      r_oe_n      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            // Write wins when both are high. Latch the request so later
            // input changes cannot disturb the access in progress.
            r_state     <= S_LO;
            r_cnt       <= '0;
            r_idx       <= w_idx;
            r_wdata     <= write_data;
            r_is_wr     <= wr_en;
            r_sram_addr <= {w_idx, 1'b0};
            r_dq_out    <= write_data[15:0];
            r_dq_oe     <= wr_en;
            r_we_n      <= !wr_en;
            r_oe_n      <= wr_en;
          end
        end
        S_LO: begin
          if (w_last) begin
            r_state     <= S_HI;
            r_cnt       <= '0;
            r_sram_addr <= {r_idx, 1'b1};
            r_dq_out    <= r_wdata[31:16];
            r_we_n      <= !r_is_wr;
            if (!r_is_wr) begin
              r_read_data[15:0] <= sram_dq_in;
            end
          end else begin
            r_cnt  <= w_cnt_inc;
            r_we_n <= w_next_we_n;
          end
        end
        S_HI: begin
          if (w_last) begin
            r_state <= S_DONE;
            r_cnt   <= '0;
            r_dq_oe <= 1'b0;
            r_we_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            if (!r_is_wr) begin
              r_read_data[31:16] <= sram_dq_in;
            end
          end else begin
            r_cnt  <= w_cnt_inc;
            r_we_n <= w_next_we_n;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign read_data   = r_read_data;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;
  assign sram_oe_n   = r_oe_n;
  assign o_dbg_state = r_state;

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Multi-cycle controller between the MEM stage and an external 16-bit asynchronous SRAM.
- Converts each 32-bit word read or write from the pipeline into two sequenced halfword SRAM accesses.
- Holds `ready` low while an access is in progress; the top level ORs `~ready` into the pipeline freeze so IF/ID/EXE/MEM registers stall until the access completes.

Parameters:
- BASE_ADDR, 1024: byte address of SRAM word 0 in the CPU address map.
- ACCESS_CYCLES, 2: cycles spent on each halfword phase; must be >= 2.
- SRAM_ADDR_W, 18: SRAM halfword address width.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  MEM-stage store request (level, held while ready=0)
- rd_en  input  1  MEM-stage load request (level, held while ready=0)
- address  input  32  byte address from EXE result
- write_data  input  32  store data (Val_Rm)
- read_data  output  32  loaded word, registered
- ready  output  1  1 = no access pending or access completing this cycle
- sram_addr  output  SRAM_ADDR_W  halfword address to SRAM
- sram_dq_out  output  16  write data to SRAM
- sram_dq_oe  output  1  1 = controller drives the DQ bus
- sram_dq_in  input  16  read data from SRAM
- sram_we_n  output  1  active-low write enable
- sram_oe_n  output  1  active-low output enable

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; counter=0.
  - Latched address and data registers = 0; read_data=0.
  - Following cycle: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, sram_addr=0, sram_dq_out=0.
  - Reset mid-access abandons the access with no completion cycle.
- Address map:
  - idx = (address - BASE_ADDR)[SRAM_ADDR_W:2], computed modulo 2^32 with no range check.
  - Low phase: sram_addr = {idx,0}, carries bits [15:0].
  - High phase: sram_addr = {idx,1}, carries bits [31:16].
- Request priority: wr_en beats rd_en when both are high; the read is ignored.
- States: IDLE, LO, HI, DONE; counter cnt counts 0..ACCESS_CYCLES-1.
  - IDLE: if wr_en|rd_en, latch address, write_data and op (write=wr_en), set cnt=0, go to LO. Otherwise stay.
  - LO: cnt increments each cycle. At cnt=ACCESS_CYCLES-1, set cnt=0 and go to HI. On a read, sram_dq_in is captured into read_data[15:0] at that edge.
  - HI: same as LO. On a read, read_data[31:16] is captured at the final edge. Then go to DONE.
  - DONE: one cycle, then unconditionally go to IDLE.
- ready is combinational: ready = (state==IDLE && !(wr_en|rd_en)) || state==DONE.
  - A request is therefore stalled from the first cycle it appears.
- Latency: a request first seen in IDLE at cycle 0 gives ready=0 in cycles 0..2*ACCESS_CYCLES and ready=1 in cycle 2*ACCESS_CYCLES+1 (cycle 5 at default).
  - The pipeline advances on the edge ending DONE.
  - Inputs seen in the next IDLE cycle belong to the next instruction; back-to-back accesses are legal.
- Write phase, each of LO and HI:
  - sram_dq_oe=1 and sram_dq_out = the latched halfword for the whole phase.
  - sram_we_n=0 for cnt < ACCESS_CYCLES-1 and 1 on the last cycle, giving address/data hold after the WE rising edge.
  - sram_oe_n=1 throughout.
- Read phase: sram_oe_n=0, sram_we_n=1, sram_dq_oe=0.
- IDLE/DONE: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
- read_data holds its value until the next read completes; writes do not alter it.
- Input changes during LO/HI are ignored because the latched copies are used.

Test Plan:
- Reset, then idle with wr_en=rd_en=0 -> ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, read_data=0.
- Write address=1024, write_data=0xDEADBEEF -> cycles 1-2 sram_addr=0, dq_out=0xBEEF, we_n=0 then 1; cycles 3-4 sram_addr=1, dq_out=0xDEAD; ready=0 cycles 0-4, ready=1 cycle 5.
- SRAM model preloaded with halfword[2]=0x5678 and halfword[3]=0x1234; read address=1028 -> sram_addr 2 then 3, oe_n=0, read_data=0x12345678 valid in cycle 5 with ready=1.
- wr_en=rd_en=1 at address=1032, write_data=0xA5A5_0F0F -> write sequence occurs (we_n pulses), read_data unchanged.
- Two back-to-back reads (1024, then 1028 presented in the IDLE cycle after DONE) -> two full 6-cycle sequences with no lost request; ACCESS_CYCLES=3 variant -> ready=1 at cycle 7.
- Assert rst during HI of a write -> next cycle state IDLE, we_n=1, dq_oe=0, no DONE/ready pulse from the aborted access.
